// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared types, defaults and parity helper for the demux8_latch slice
package demux_pkg;

  // Default select width: 3 select bits give 8 outputs.
  localparam int SEL_W_DEF = 3;

  // Frame controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // XOR-reduce a zero-extended vector; 0 means the vector holds an even number of ones.
  function automatic logic even_parity(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/demux8_latch_scan_ctr.sv
// rtl/demux8_latch_scan_ctr.sv - frame bit counter with clear, enable and terminal-count flag
module scan_ctr #(
  parameter int           W  = 4,
  parameter logic [W-1:0] TC = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;

  // Count enabled beats; the beat taken at the terminal count wraps back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC);

endmodule

// File: rtl/demux8_latch.sv
// rtl/demux8_latch.sv - clocked 1-to-N demux with output latches; DEMUX8_LATCH_PARITY_EN adds a parity beat
module demux8_latch
  import demux_pkg::*;
#(
  parameter int                   SEL_W   = SEL_W_DEF,
  parameter logic [2**SEL_W-1:0]  RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 D,
  input  logic [SEL_W-1:0]     A,
  input  logic                 E_n,
  input  logic                 AUTO,
  input  logic                 START,
  output logic [2**SEL_W-1:0]  Q,
  output logic [2**SEL_W-1:0]  Q_n,
  output logic                 busy,
`ifdef DEMUX8_LATCH_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 frame_done
);

  localparam int N  = 2**SEL_W;
  localparam int CW = SEL_W + 1;

  // With parity the frame carries one extra beat (index N) holding P.
`ifdef DEMUX8_LATCH_PARITY_EN
  localparam logic [CW-1:0] LAST_BEAT = CW'(N);
`else
  localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);
`endif

  state_e         state_q;
  logic [N-1:0]   q_q;
  logic [N-1:0]   shadow_q;
  logic [N-1:0]   shadow_d;
  logic           busy_q;
  logic           frame_done_q;
`ifdef DEMUX8_LATCH_PARITY_EN
  logic           parity_err_q;
`endif

  logic [CW-1:0]  cnt;
  logic           last_beat;
  logic           cnt_clr;
  logic           cnt_en;

  assign cnt_clr = (state_q == ST_IDLE) && AUTO && START;
  assign cnt_en  = (state_q == ST_SCAN) && !E_n;

  scan_ctr #(
    .W  (CW),
    .TC (LAST_BEAT)
  ) u_scan_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .tc_o  (last_beat)
  );

  // Shadow with the current beat merged in, so the final data bit lands in Q on the same edge.
  always_comb begin
    shadow_d = shadow_q;
    if (cnt_en && !cnt[SEL_W]) begin
      shadow_d[cnt[SEL_W-1:0]] = D;
    end
  end

  // Frame FSM together with the output latch array and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      q_q          <= RST_VAL;
      shadow_q     <= RST_VAL;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef DEMUX8_LATCH_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          frame_done_q <= 1'b0;
          if (AUTO) begin
            if (START) begin
              state_q <= ST_SCAN;
              busy_q  <= 1'b1;
            end
          end else if (!E_n) begin
            q_q[A] <= D;
          end
        end
        ST_SCAN: begin
          shadow_q <= shadow_d;
          if (cnt_en && last_beat) begin
            q_q          <= shadow_d;
            state_q      <= ST_DONE;
            frame_done_q <= 1'b1;
`ifdef DEMUX8_LATCH_PARITY_EN
            parity_err_q <= even_parity(64'({shadow_q, D}));
`endif
          end
        end
        ST_DONE: begin
          frame_done_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: begin
          state_q      <= ST_IDLE;
          busy_q       <= 1'b0;
          frame_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign Q          = q_q;
  assign Q_n        = ~q_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
`ifdef DEMUX8_LATCH_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_demux8_latch.sv
// tb/tb_demux8_latch.sv - directed self-checking bench for demux8_latch
module tb_demux8_latch;

`ifdef DEMUX8_LATCH_PARITY_EN
  localparam int NBEATS = 9;
`else
  localparam int NBEATS = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       D;
  logic [2:0] A;
  logic       E_n;
  logic       AUTO;
  logic       START;
  logic [7:0] Q;
  logic [7:0] Q_n;
  logic       busy;
  logic       frame_done;
`ifdef DEMUX8_LATCH_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  demux8_latch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D          (D),
    .A          (A),
    .E_n        (E_n),
    .AUTO       (AUTO),
    .START      (START),
    .Q          (Q),
    .Q_n        (Q_n),
    .busy       (busy),
`ifdef DEMUX8_LATCH_PARITY_EN
    .parity_err (parity_err),
`endif
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // One auto-scan frame, optionally stalled after beat stall_after with START/A/AUTO toggling.
  task automatic run_frame(input logic [7:0] bits, input int stall_after, input int stall_len,
                           input logic p, input logic [7:0] q_old);
    AUTO = 1'b1; START = 1'b1; E_n = 1'b1; D = 1'b0;
    @(negedge clk);
    check_eq("start_busy", 8'(busy), 8'd1);
    check_eq("start_q_hold", Q, q_old);
    START = 1'b0;
    for (int i = 0; i < NBEATS; i++) begin
      E_n = 1'b0;
      D   = (i < 8) ? bits[i] : p;
      @(negedge clk);
      if (i == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          E_n = 1'b1; START = 1'b1; A = ~A; AUTO = 1'b0;
          @(negedge clk);
          check_eq("stall_no_done", 8'(frame_done), 8'd0);
          check_eq("stall_q_hold", Q, q_old);
        end
        START = 1'b0; AUTO = 1'b1;
      end
      if (i < NBEATS - 1) begin
        check_eq("scan_q_hold", Q, q_old);
        check_eq("scan_busy", 8'(busy), 8'd1);
      end
    end
    E_n = 1'b1;
    check_eq("frame_q", Q, bits);
    check_eq("frame_qn", Q_n, ~bits);
    check_eq("frame_done_pulse", 8'(frame_done), 8'd1);
    check_eq("done_busy", 8'(busy), 8'd1);
`ifdef DEMUX8_LATCH_PARITY_EN
    check_eq("parity_err", 8'(parity_err), 8'(^{bits, p}));
`endif
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    check_eq("done_pulse_end", 8'(frame_done), 8'd0);
    check_eq("idle_busy", 8'(busy), 8'd0);
    @(negedge clk);
    check_eq("done_start_ignored", 8'(busy), 8'd0);
    check_eq("idle_q_hold", Q, bits);
  endtask

  initial begin
    rst_n = 1'b0; D = 1'b0; A = 3'd0; E_n = 1'b1; AUTO = 1'b0; START = 1'b0;
    #1;
    check_eq("rst_q", Q, 8'h00);
    check_eq("rst_qn", Q_n, 8'hFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_q", Q, 8'h00);
    check_eq("post_rst_busy", 8'(busy), 8'd0);
    check_eq("post_rst_done", 8'(frame_done), 8'd0);
`ifdef DEMUX8_LATCH_PARITY_EN
    check_eq("post_rst_perr", 8'(parity_err), 8'd0);
`endif

    // Addressable writes.
    E_n = 1'b0; A = 3'd5; D = 1'b1;
    @(negedge clk);
    check_eq("addr_a5", Q, 8'h20);
    A = 3'd0; D = 1'b1;
    @(negedge clk);
    check_eq("addr_a0", Q, 8'h21);
    check_eq("addr_a0_qn", Q_n, 8'hDE);
    E_n = 1'b1; A = 3'd0; D = 1'b0;
    @(negedge clk);
    check_eq("addr_disabled", Q, 8'h21);
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    check_eq("start_no_auto", 8'(busy), 8'd0);

    // Plain frame 8'h4D.
    run_frame(8'h4D, -1, 0, 1'b0, 8'h21);

    // Clear bit 0 so the stalled frame visibly changes Q.
    AUTO = 1'b0; E_n = 1'b0; A = 3'd0; D = 1'b0;
    @(negedge clk);
    E_n = 1'b1;
    check_eq("addr_clear", Q, 8'h4C);
    run_frame(8'h4D, 3, 3, 1'b1, 8'h4C);

    // Abort mid-frame with an asynchronous reset.
    AUTO = 1'b1; START = 1'b1; E_n = 1'b1;
    @(negedge clk);
    START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      E_n = 1'b0; D = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_eq("abort_q", Q, 8'h00);
    check_eq("abort_qn", Q_n, 8'hFF);
    check_eq("abort_busy", 8'(busy), 8'd0);
    check_eq("abort_done", 8'(frame_done), 8'd0);
    @(negedge clk);
    E_n = 1'b1; AUTO = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_idle_q", Q, 8'h00);
    check_eq("abort_idle_busy", 8'(busy), 8'd0);
    check_eq("abort_idle_done", 8'(frame_done), 8'd0);

    run_frame(8'hFF, -1, 0, 1'b0, 8'h00);

`ifdef DEMUX8_LATCH_PARITY_EN
    run_frame(8'h4D, -1, 0, 1'b0, 8'hFF);
    run_frame(8'h4D, -1, 0, 1'b1, 8'h4D);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux8_latch.md
Name: demux8_latch

Overview:
- Clocked 1-to-8 demultiplexer with output latches; the receive-side counterpart of the team's 8:1 data-select mux.
- Serial bits selected onto one line by the mux are steered back into 8 parallel latched outputs.
- Two modes:
  - Addressable: one write per cycle to the bit selected by A.
  - Auto-scan: an 8-bit frame is captured on consecutive enabled cycles, then transferred atomically to Q.

Parameters:
- SEL_W, 3, select width; number of outputs N = 2**SEL_W (8 at default).
- RST_VAL, {N{1'b0}}, value loaded into Q and the shadow register at reset.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset; assertion is asynchronous, release is synchronous to clk.
- D  input  1  serial data bit to steer.
- A  input  SEL_W  destination index for addressable mode.
- E_n  input  1  active-low enable; when high, the cycle does nothing.
- AUTO  input  1  mode select: 0 = addressable, 1 = auto-scan. Sampled only in IDLE.
- START  input  1  single-cycle pulse that begins an auto-scan frame.
- Q  output  N  latched parallel outputs.
- Q_n  output  N  bitwise inverse of Q.
- busy  output  1  high while a frame is in progress (SCAN or DONE state).
- frame_done  output  1  one-cycle pulse, high the cycle after Q is updated from the shadow register.

Behaviour:
- Reset (async, rst_n=0):
  - Q=RST_VAL, shadow=RST_VAL, cnt=0, state=IDLE, busy=0, frame_done=0.
  - Reset asserted mid-frame aborts the frame; the partial shadow contents are discarded.
- States: IDLE, SCAN, DONE.
- IDLE:
  - AUTO=0 and E_n=0: Q[A]<=D at the clock edge, all other Q bits hold. Latency 1 cycle.
  - AUTO=1 and START=1: go to SCAN with cnt=0. E_n is ignored on the START cycle.
  - AUTO=1 and START=0: hold.
  - START is ignored when AUTO=0.
- SCAN:
  - E_n=0: shadow[cnt]<=D, cnt<=cnt+1. Capture order is LSB first (index 0 first).
  - E_n=1: stall; cnt and shadow hold, no timeout.
  - Capture at cnt=N-1: cnt wraps to 0, next state DONE, Q<=shadow with the final bit merged in the same edge.
  - Q is unchanged until the frame completes.
  - START, A, and AUTO are ignored while busy.
- DONE:
  - frame_done=1 for exactly one cycle, busy=1, then IDLE unconditionally.
  - A START arriving in DONE is ignored; a new frame needs START in IDLE.
- Timing: minimum frame is START plus N enabled cycles plus 1 DONE cycle.
  - START at edge 0 → busy=1 from edge 0 → Q updated at edge N → frame_done high during cycle N+1 → IDLE after edge N+1.
- Output rules:
  - Q_n is combinational ~Q.
  - All outputs are registered except Q_n.
  - No tri-state; when E_n is high, Q simply holds.

Optional Feature:
- DEMUX8_LATCH_PARITY_EN
- Defined:
  - The frame gains one extra enabled SCAN cycle (cnt=N) that captures an even-parity bit P.
  - Adds output parity_err, 1 bit, reset 0, registered.
  - At frame end parity_err<=^{shadow,P}, updated in the same edge as Q. Q is transferred even when parity fails.
  - parity_err holds until the next frame end or reset.
- Undefined: no parity_err port, N-cycle frames, cnt range 0..N-1.

Decomposition:
- Shared package demux_pkg:
  - state enum (IDLE/SCAN/DONE, 2 bits).
  - SEL_W default constant.
  - Parity helper function.
- One natural sub-module, scan_ctr: an SEL_W+1-bit counter with clear, enable, and terminal-count flag, used for cnt and the wrap/DONE decision.
- Latch array and FSM stay in the top module.

Test Plan:
- Reset: drive rst_n=0 mid-simulation at an arbitrary time → Q=8'h00, Q_n=8'hFF, busy=0 with no clock edge needed; release → all outputs hold.
- Addressable writes, AUTO=0:
  - E_n=0, A=5, D=1 → Q=8'h20 next cycle.
  - Then A=0, D=1 → Q=8'h21.
  - E_n=1, A=0, D=0 → Q stays 8'h21.
- Auto frame: AUTO=1, START pulse, D sequence 1,0,1,1,0,0,1,0 on 8 enabled cycles → Q=8'h4D at edge 8, frame_done high one cycle, busy low after.
- Stall and ignore:
  - Same frame with E_n=1 for 3 cycles after bit 3 → Q=8'h4D delayed by 3 cycles.
  - Q keeps its old value until completion.
  - START and A toggles mid-frame have no effect.
- Abort: start a frame, assert rst_n=0 after 4 bits → Q=RST_VAL, IDLE, no frame_done.
  - A later full frame of 8'hFF → Q=8'hFF.
- Parity, with DEMUX8_LATCH_PARITY_EN defined:
  - Frame 8'h4D with P=0 → parity_err=0.
  - Frame 8'h4D with P=1 → parity_err=1 and Q=8'h4D.
